mipi_csi_rx_packet_decoder: RTL
===============================

Name: mipi_csi_rx_packet_decoder

Overview:
- Sits between the lane-merge stage and the header ECC stage of the CSI-2 RX.
- Takes a merged 4-lane byte stream as 32-bit words, one packet per HS burst.
- Extracts the 4-byte packet header and sends it to the header ECC block, then uses the corrected header fields that block returns.
- Long packets: strips payload and the 16-bit CRC, emitting payload words with byte enables. Short packets: reported as single events.

Parameters:
LONG_DT_MIN, 6'h10, data types >= this value are long packets; lower values are short packets
WC_W, 16, width of the internal remaining-byte counter

Ports:
clk_i  input  1  clock
reset_n_i  input  1  asynchronous active-low reset
data_valid_i  input  1  merged word valid; low marks end of HS burst
data_i  input  32  merged word; [7:0] is the first byte on the wire, [31:24] the fourth
packet_header_valid_o  output  1  header word presented to ECC block (combinational)
packet_header_o  output  32  {byte0,byte1,byte2,byte3} = {DataID,WC LSB,WC MSB,ECC}
packet_length_i  input  16  corrected WC from ECC block (same-cycle return)
vc_id_i  input  2  corrected virtual channel
data_type_i  input  6  corrected data type
no_error_i  input  1  ECC: clean header
corrected_error_i  input  1  ECC: 1-bit error corrected
error_i  input  1  ECC: uncorrectable header
header_valid_o  output  1  1-cycle pulse: corrected header accepted
vc_id_o  output  2  latched VC
data_type_o  output  6  latched data type
packet_length_o  output  16  latched WC (short packet: 16-bit data field)
short_pkt_valid_o  output  1  1-cycle pulse: short packet decoded
header_corrected_o  output  1  1-cycle pulse: header needed 1-bit correction
header_error_o  output  1  1-cycle pulse: uncorrectable header, packet dropped
payload_valid_o  output  1  payload word valid
payload_data_o  output  32  payload bytes, same byte order as data_i
payload_byte_en_o  output  4  valid bytes; bit n covers [8n+7:8n]
payload_last_o  output  1  last payload word of packet
crc_valid_o  output  1  1-cycle pulse with received CRC
crc_o  output  16  received CRC; first CRC byte is bits [7:0]
packet_abort_o  output  1  1-cycle pulse: burst ended before packet complete

Behaviour:
- Reset: all outputs 0. State IDLE, counters 0.
- No backpressure. Every word with data_valid_i=1 is consumed in the cycle it arrives.
- packet_header_o = {data_i[7:0],data_i[15:8],data_i[23:16],data_i[31:24]}.
- packet_header_valid_o = data_valid_i & (state==IDLE).
- States: IDLE, PAYLOAD, CRC, WAIT_END.
- IDLE, word valid:
  - error_i=1: header_error_o pulses, go to WAIT_END.
  - Otherwise latch vc/dt/length and pulse header_valid_o (latency 1); also pulse header_corrected_o if corrected_error_i=1.
  - data_type_i < LONG_DT_MIN: short_pkt_valid_o pulses, go to WAIT_END.
  - Long packet with WC=0: go to CRC with crc_lo_pending=1.
  - Otherwise load remaining = WC, go to PAYLOAD.
- PAYLOAD, word valid: payload_valid_o=1 next cycle (latency 1).
  - remaining > 4: byte_en=4'b1111, remaining -= 4.
  - remaining <= 4 (last word): byte_en = 0001/0011/0111/1111 for remaining 1/2/3/4, and payload_last_o=1. Let r = remaining.
  - r=4: CRC is in next word bytes 0,1; go to CRC.
  - r=3: byte 3 is CRC LSB; go to CRC for MSB in the next word's byte 0.
  - r=2: CRC is bytes 2,3; crc_valid_o pulses, go to WAIT_END.
  - r=1: CRC is bytes 1,2; crc_valid_o pulses, go to WAIT_END.
- CRC, word valid: take remaining CRC byte(s) from byte 0 (and byte 1 if both pending). crc_valid_o pulses next cycle, go to WAIT_END.
- WAIT_END: ignore words (trailer/padding). data_valid_i=0 returns to IDLE next cycle.
- data_valid_i=0 in PAYLOAD or CRC: packet_abort_o pulses, go to IDLE. No payload_last_o or crc_valid_o is issued.
- data_valid_i=0 in IDLE: stay in IDLE, no outputs.
- Latched vc/dt/length hold until the next accepted header.
- Counter arithmetic is unsigned WC_W bits. WC=16'hFFFF must complete without wrap: 16383 full words, then a last word with byte_en=0111 (r=3), then the CRC state.
- Async reset mid-packet: immediate return to IDLE, outputs 0, no abort pulse.

Test Plan:
- Long packet RAW8, DataID 0x2A, WC=6, correct ECC, 3 payload words -> header_valid_o with dt=0x2A, length=6; word1 byte_en 1111; word2 byte_en 0011 with last; crc_o from word2 bytes 2,3; crc_valid_o.
- Short packet FS, DataID 0x00, WC field 0x0001 -> short_pkt_valid_o, packet_length_o=1; no payload_valid_o; later words ignored until data_valid_i low.
- WC=7 and WC=8 -> WC=7: last byte_en 0111, CRC split across byte 3 and next byte 0. WC=8: last byte_en 1111, CRC in next word bytes 0,1. crc_o matches injected 0xBEEF in both cases.
- Single-bit flip in WC MSB with valid ECC -> header_corrected_o pulse, corrected length used for payload count. Two-bit flip -> header_error_o, no payload output, back in IDLE after data_valid_i low.
- Long packet WC=16, data_valid_i dropped after 2 payload words -> 2 payload_valid_o cycles, packet_abort_o pulse, no payload_last_o, next header decodes normally.
- Reset asserted during PAYLOAD of a WC=64 packet -> all outputs 0 immediately; a new header after reset release decodes correctly.

Source files
------------

// File: rtl/mipi_csi_rx_packet_decoder_if.sv
// Word stream from the lane merge stage plus the payload stream handed downstream.
interface mipi_csi_rx_packet_decoder_if;
  logic        data_valid;
  logic [31:0] data;
  logic        payload_valid;
  logic [31:0] payload_data;
  logic [3:0]  payload_byte_en;
  logic        payload_last;

  modport master (
    output data_valid, data,
    input  payload_valid, payload_data, payload_byte_en, payload_last
  );
  modport slave (
    input  data_valid, data,
    output payload_valid, payload_data, payload_byte_en, payload_last
  );
endinterface

// File: rtl/mipi_csi_rx_packet_decoder.sv
// CSI-2 RX packet decoder: splits each HS burst into header, payload words and CRC,
// using the corrected header fields returned by the header ECC stage.
module mipi_csi_rx_packet_decoder #(
  parameter logic [5:0] LONG_DT_MIN = 6'h10,
  parameter int         WC_W        = 16
) (
  input  logic        clk_i,
  input  logic        reset_n_i,
  mipi_csi_rx_packet_decoder_if.slave bus,
  output logic        packet_header_valid_o,
  output logic [31:0] packet_header_o,
  input  logic [15:0] packet_length_i,
  input  logic [1:0]  vc_id_i,
  input  logic [5:0]  data_type_i,
  input  logic        no_error_i,
  input  logic        corrected_error_i,
  input  logic        error_i,
  output logic        header_valid_o,
  output logic [1:0]  vc_id_o,
  output logic [5:0]  data_type_o,
  output logic [15:0] packet_length_o,
  output logic        short_pkt_valid_o,
  output logic        header_corrected_o,
  output logic        header_error_o,
  output logic        crc_valid_o,
  output logic [15:0] crc_o,
  output logic        packet_abort_o
);

  typedef enum logic [1:0] {IDLE, PAYLOAD, CRC, WAIT_END} state_e;

  state_e          state_q, state_d;
  logic [WC_W-1:0] rem_q, rem_d;
  logic            crc_both_q, crc_both_d;
  logic [7:0]      crc_lo_q, crc_lo_d;
  logic            hv_q, hv_d, short_q, short_d, corr_q, corr_d, herr_q, herr_d;
  logic [1:0]      vc_q, vc_d;
  logic [5:0]      dt_q, dt_d;
  logic [15:0]     len_q, len_d;
  logic            pv_q, pv_d, plast_q, plast_d;
  logic [31:0]     pdata_q, pdata_d;
  logic [3:0]      pbe_q, pbe_d;
  logic            crcv_q, crcv_d, abort_q, abort_d;
  logic [15:0]     crc_q, crc_d;
  logic            unused_no_error;

  // A clean header needs no action beyond the absence of the other two flags.
  assign unused_no_error = no_error_i;

  assign packet_header_valid_o = reset_n_i & bus.data_valid & (state_q == IDLE);
  assign packet_header_o = reset_n_i ?
    {bus.data[7:0], bus.data[15:8], bus.data[23:16], bus.data[31:24]} : 32'h0;

  always_comb begin
    state_d    = state_q;
    rem_d      = rem_q;
    crc_both_d = crc_both_q;
    crc_lo_d   = crc_lo_q;
    hv_d       = 1'b0;
    vc_d       = vc_q;
    dt_d       = dt_q;
    len_d      = len_q;
    short_d    = 1'b0;
    corr_d     = 1'b0;
    herr_d     = 1'b0;
    pv_d       = 1'b0;
    pdata_d    = pdata_q;
    pbe_d      = 4'h0;
    plast_d    = 1'b0;
    crcv_d     = 1'b0;
    crc_d      = crc_q;
    abort_d    = 1'b0;
    unique case (state_q)
      IDLE: if (bus.data_valid) begin
        if (error_i) begin
          herr_d  = 1'b1;
          state_d = WAIT_END;
        end else begin
          hv_d   = 1'b1;
          corr_d = corrected_error_i;
          vc_d   = vc_id_i;
          dt_d   = data_type_i;
          len_d  = packet_length_i;
          if (data_type_i < LONG_DT_MIN) begin
            short_d = 1'b1;
            state_d = WAIT_END;
          end else if (packet_length_i == 16'h0) begin
            crc_both_d = 1'b1;
            state_d    = CRC;
          end else begin
            rem_d   = WC_W'(packet_length_i);
            state_d = PAYLOAD;
          end
        end
      end
      PAYLOAD: if (!bus.data_valid) begin
        abort_d = 1'b1;
        state_d = IDLE;
      end else begin
        pv_d    = 1'b1;
        pdata_d = bus.data;
        if (rem_q > WC_W'(4)) begin
          pbe_d = 4'hF;
          rem_d = rem_q - WC_W'(4);
        end else begin
          plast_d = 1'b1;
          rem_d   = '0;
          // The CRC starts right after the last payload byte, wherever that lands.
          case (rem_q[2:0])
            3'd1: begin
              pbe_d = 4'b0001; crcv_d = 1'b1; crc_d = bus.data[23:8]; state_d = WAIT_END;
            end
            3'd2: begin
              pbe_d = 4'b0011; crcv_d = 1'b1; crc_d = bus.data[31:16]; state_d = WAIT_END;
            end
            3'd3: begin
              pbe_d = 4'b0111; crc_lo_d = bus.data[31:24]; crc_both_d = 1'b0; state_d = CRC;
            end
            default: begin
              pbe_d = 4'hF; crc_both_d = 1'b1; state_d = CRC;
            end
          endcase
        end
      end
      CRC: if (!bus.data_valid) begin
        abort_d = 1'b1;
        state_d = IDLE;
      end else begin
        crcv_d  = 1'b1;
        crc_d   = crc_both_q ? bus.data[15:0] : {bus.data[7:0], crc_lo_q};
        state_d = WAIT_END;
      end
      WAIT_END: if (!bus.data_valid) state_d = IDLE;
      default: state_d = IDLE;
    endcase
  end

  always_ff @(posedge clk_i or negedge reset_n_i) begin
    if (!reset_n_i) begin
      state_q    <= IDLE;
      rem_q      <= '0;
      crc_both_q <= 1'b0;
      crc_lo_q   <= 8'h0;
      hv_q       <= 1'b0;
      vc_q       <= 2'h0;
      dt_q       <= 6'h0;
      len_q      <= 16'h0;
      short_q    <= 1'b0;
      corr_q     <= 1'b0;
      herr_q     <= 1'b0;
      pv_q       <= 1'b0;
      pdata_q    <= 32'h0;
      pbe_q      <= 4'h0;
      plast_q    <= 1'b0;
      crcv_q     <= 1'b0;
      crc_q      <= 16'h0;
      abort_q    <= 1'b0;
    end else begin
      state_q    <= state_d;
      rem_q      <= rem_d;
      crc_both_q <= crc_both_d;
      crc_lo_q   <= crc_lo_d;
      hv_q       <= hv_d;
      vc_q       <= vc_d;
      dt_q       <= dt_d;
      len_q      <= len_d;
      short_q    <= short_d;
      corr_q     <= corr_d;
      herr_q     <= herr_d;
      pv_q       <= pv_d;
      pdata_q    <= pdata_d;
      pbe_q      <= pbe_d;
      plast_q    <= plast_d;
      crcv_q     <= crcv_d;
      crc_q      <= crc_d;
      abort_q    <= abort_d;
    end
  end

  assign header_valid_o      = hv_q;
  assign vc_id_o             = vc_q;
  assign data_type_o         = dt_q;
  assign packet_length_o     = len_q;
  assign short_pkt_valid_o   = short_q;
  assign header_corrected_o  = corr_q;
  assign header_error_o      = herr_q;
  assign bus.payload_valid   = pv_q;
  assign bus.payload_data    = pdata_q;
  assign bus.payload_byte_en = pbe_q;
  assign bus.payload_last    = plast_q;
  assign crc_valid_o         = crcv_q;
  assign crc_o               = crc_q;
  assign packet_abort_o      = abort_q;

endmodule
